// File: rtl/gdb_pkg.sv
// Shared constants, FSM state type and character helpers for the GDB packet framer.
// Optional ack/retransmit support is enabled with the GDB_PKT_ACK_EN macro.
package gdb_pkg;

  localparam logic [7:0] CHAR_DOLLAR = 8'h24;
  localparam logic [7:0] CHAR_HASH   = 8'h23;
  localparam logic [7:0] CHAR_STAR   = 8'h2A;
  localparam logic [7:0] CHAR_ESCAPE = 8'h7D;
  localparam logic [7:0] ESC_XOR     = 8'h20;
`ifdef GDB_PKT_ACK_EN
  localparam logic [7:0] CHAR_PLUS   = 8'h2B;
  localparam logic [7:0] CHAR_MINUS  = 8'h2D;
`endif

  typedef enum logic [3:0] {
    IDLE, FILL, TX_DOLLAR, TX_BODY, TX_HASH, TX_CS_HI, TX_CS_LO, TX_WAIT, WAIT_ACK
  } state_t;

  // Nibble to lowercase ASCII hex digit.
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    return (nib < 4'd10) ? 8'(8'h30 + 8'(nib)) : 8'(8'h57 + 8'(nib));
  endfunction

  // Bytes that must be sent as '}' followed by byte^0x20.
  function automatic logic needs_escape(input logic [7:0] b);
    return (b == CHAR_HASH) || (b == CHAR_DOLLAR) || (b == CHAR_STAR) || (b == CHAR_ESCAPE);
  endfunction

endpackage

// File: rtl/gdb_char_buf.sv
// Encoded-character replay buffer: one/two-char write per cycle, registered read.
module gdb_char_buf #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic          wr_two_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_dat0_i,
  input  logic [7:0]    wr_dat1_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_dat_o
);

  logic [7:0] mem [DEPTH];

  // Write encoded chars at consecutive addresses; read is one cycle late.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_dat0_i;
      if (wr_two_i) mem[AW'(wr_addr_i + 1'b1)] <= wr_dat1_i;
    end
    rd_dat_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/gdb_packet_tx.sv
// GDB remote-protocol transmit framer: "$<encoded payload>#cc" onto the debug UART.
// Define GDB_PKT_ACK_EN to wait for '+'/'-' acks and retransmit on '-'.
module gdb_packet_tx
  import gdb_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 64,
  parameter int unsigned AW        = 6,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] pl_dat_i,
  input  logic       pl_hex_i,
  input  logic       pl_last_i,
  input  logic       pl_valid_i,
  output logic       pl_ready_o,
  input  logic       send_empty_i,
  output logic [7:0] uart_tx_byte_o,
  output logic       uart_transmit_o,
  input  logic       uart_is_transmitting_i,
  input  logic       ack_valid_i,
  input  logic [7:0] ack_byte_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = AW + 2;

  state_t        state, ret, tx_next;
  logic          wait_cnt, drop;
  logic [CW-1:0] count, idx;
  logic [7:0]    cs, c0, c1, sum, tx_char, rd_dat;
  logic          two, accept, ovf, wr_en, is_tx;
  logic [LW-1:0] need;
  logic [AW-1:0] wr_addr;

`ifdef GDB_PKT_ACK_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry;
`else
  logic unused_ack;
  assign unused_ack = ^{ack_valid_i, ack_byte_i, 32'(MAX_RETRY)};
`endif

  // Encode one payload beat into one or two chars and their checksum contribution.
  always_comb begin
    two = pl_hex_i | needs_escape(pl_dat_i);
    c0  = pl_dat_i;
    c1  = 8'h00;
    if (pl_hex_i) begin
      c0 = nib2hex(pl_dat_i[7:4]);
      c1 = nib2hex(pl_dat_i[3:0]);
    end else if (needs_escape(pl_dat_i)) begin
      c0 = CHAR_ESCAPE;
      c1 = pl_dat_i ^ ESC_XOR;
    end
    sum     = 8'(c0 + c1);
    accept  = pl_valid_i & pl_ready_o;
    need    = LW'(count) + (two ? LW'(2) : LW'(1));
    ovf     = need > LW'(BUF_DEPTH);
    wr_en   = accept & (((state == IDLE) & ~drop) | ((state == FILL) & ~ovf));
    wr_addr = (state == IDLE) ? '0 : count[AW-1:0];
  end

  // Character to send in the current TX state and the state that follows it.
  always_comb begin
    tx_char = CHAR_DOLLAR;
    tx_next = TX_HASH;
    is_tx   = 1'b1;
    case (state)
      TX_DOLLAR: tx_next = (count == '0) ? TX_HASH : TX_BODY;
      TX_BODY: begin
        tx_char = rd_dat;
        tx_next = (CW'(idx + 1'b1) == count) ? TX_HASH : TX_BODY;
      end
      TX_HASH: begin
        tx_char = CHAR_HASH;
        tx_next = TX_CS_HI;
      end
      TX_CS_HI: begin
        tx_char = nib2hex(cs[7:4]);
        tx_next = TX_CS_LO;
      end
      TX_CS_LO: begin
        tx_char = nib2hex(cs[3:0]);
`ifdef GDB_PKT_ACK_EN
        tx_next = WAIT_ACK;
`else
        tx_next = IDLE;
`endif
      end
      default: is_tx = 1'b0;
    endcase
  end

  gdb_char_buf #(.DEPTH(BUF_DEPTH), .AW(AW)) u_buf (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_two_i  (two),
    .wr_addr_i (wr_addr),
    .wr_dat0_i (c0),
    .wr_dat1_i (c1),
    .rd_addr_i (idx[AW-1:0]),
    .rd_dat_o  (rd_dat)
  );

  // Packet FSM: fill, frame, send chars paced by the uart, optional ack handling.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      ret             <= IDLE;
      wait_cnt        <= 1'b0;
      drop            <= 1'b0;
      count           <= '0;
      idx             <= '0;
      cs              <= '0;
      pl_ready_o      <= 1'b1;
      busy_o          <= 1'b0;
      uart_tx_byte_o  <= '0;
      uart_transmit_o <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
`ifdef GDB_PKT_ACK_EN
      retry           <= '0;
`endif
    end else begin
      uart_transmit_o <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      if (is_tx) begin
        if (!uart_is_transmitting_i) begin
          uart_tx_byte_o  <= tx_char;
          uart_transmit_o <= 1'b1;
          ret             <= tx_next;
          wait_cnt        <= 1'b0;
          state           <= TX_WAIT;
          if (state == TX_DOLLAR) idx <= '0;
          else if (state == TX_BODY) idx <= CW'(idx + 1'b1);
        end
      end else begin
        case (state)
          IDLE: begin
`ifdef GDB_PKT_ACK_EN
            retry <= '0;
`endif
            if (pl_valid_i) begin
              if (drop) begin
                if (pl_last_i) drop <= 1'b0;
              end else begin
                count  <= two ? CW'(2) : CW'(1);
                cs     <= sum;
                busy_o <= 1'b1;
                if (pl_last_i) begin
                  state      <= TX_DOLLAR;
                  pl_ready_o <= 1'b0;
                end else begin
                  state <= FILL;
                end
              end
            end else if (send_empty_i && !drop) begin
              count      <= '0;
              cs         <= '0;
              state      <= TX_DOLLAR;
              pl_ready_o <= 1'b0;
              busy_o     <= 1'b1;
            end
          end
          FILL: begin
            if (accept) begin
              if (ovf) begin
                err_o  <= 1'b1;
                drop   <= ~pl_last_i;
                state  <= IDLE;
                busy_o <= 1'b0;
              end else begin
                count <= CW'(count + (two ? CW'(2) : CW'(1)));
                cs    <= 8'(cs + sum);
                if (pl_last_i) begin
                  state      <= TX_DOLLAR;
                  pl_ready_o <= 1'b0;
                end
              end
            end
          end
          TX_WAIT: begin
            if (wait_cnt) begin
              state <= ret;
              if (ret == IDLE) begin
                done_o     <= 1'b1;
                pl_ready_o <= 1'b1;
                busy_o     <= 1'b0;
              end
            end else begin
              wait_cnt <= 1'b1;
            end
          end
`ifdef GDB_PKT_ACK_EN
          WAIT_ACK: begin
            if (ack_valid_i && ack_byte_i == CHAR_PLUS) begin
              done_o     <= 1'b1;
              state      <= IDLE;
              pl_ready_o <= 1'b1;
              busy_o     <= 1'b0;
            end else if (ack_valid_i && ack_byte_i == CHAR_MINUS) begin
              if (retry < RW'(MAX_RETRY)) begin
                retry <= RW'(retry + 1'b1);
                state <= TX_DOLLAR;
              end else begin
                err_o      <= 1'b1;
                state      <= IDLE;
                pl_ready_o <= 1'b1;
                busy_o     <= 1'b0;
              end
            end
          end
`endif
          default: begin
            state      <= IDLE;
            pl_ready_o <= 1'b1;
            busy_o     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gdb_packet_tx.sv
// Directed bench for gdb_packet_tx with a character scoreboard and a simple uart busy model.
// Ack/retransmit checks run when GDB_PKT_ACK_EN is defined.
module tb_gdb_packet_tx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] pl_dat_i = '0;
  logic       pl_hex_i = 1'b0, pl_last_i = 1'b0, pl_valid_i = 1'b0, send_empty_i = 1'b0;
  logic       pl_ready_o;
  logic [7:0] uart_tx_byte_o;
  logic       uart_transmit_o, uart_is_transmitting_i;
  logic       ack_valid_i = 1'b0;
  logic [7:0] ack_byte_i = '0;
  logic       busy_o, done_o, err_o;

  gdb_packet_tx dut (
    .clk_i(clk_i), .rst_i(rst_i), .pl_dat_i(pl_dat_i), .pl_hex_i(pl_hex_i),
    .pl_last_i(pl_last_i), .pl_valid_i(pl_valid_i), .pl_ready_o(pl_ready_o),
    .send_empty_i(send_empty_i), .uart_tx_byte_o(uart_tx_byte_o),
    .uart_transmit_o(uart_transmit_o), .uart_is_transmitting_i(uart_is_transmitting_i),
    .ack_valid_i(ack_valid_i), .ack_byte_i(ack_byte_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, err_cnt = 0, strobes = 0;
  int exp_done = 0, exp_err = 0;
  logic [7:0] sb_q[$], frame_q[$], pl_q[$];
  bit hx_q[$];
  string hexs = "0123456789abcdef";

  // uart stays busy for a few cycles after each strobe
  int ubusy = 0;
  assign uart_is_transmitting_i = (ubusy != 0);
  always @(posedge clk_i) begin
    if (uart_transmit_o) ubusy <= 4;
    else if (ubusy > 0) ubusy <= ubusy - 1;
  end

  // monitor: count pulses, compare every uart char against the scoreboard
  logic [7:0] exp_c;
  bit had, prev_tx = 1'b0;
  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    if (!rst_i && uart_transmit_o) begin
      strobes++;
      had = (sb_q.size() != 0);
      exp_c = 8'hxx;
      if (had) exp_c = sb_q.pop_front();
      vectors++;
      assert (had && uart_tx_byte_o === exp_c) else begin
        miscompares++;
        $error("FAIL uart_char obs=%02h exp=%02h (expected present=%0d)", uart_tx_byte_o, exp_c, had);
      end
      vectors++;
      assert (!prev_tx) else begin
        miscompares++;
        $error("FAIL strobe_width obs=2+ cycles exp=1 cycle");
      end
    end
    prev_tx = uart_transmit_o && !rst_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference encoder: builds the expected frame for pl_q/hx_q
  task automatic build_expected(output bit ovf);
    logic [7:0] enc[$];
    logic [7:0] b, cs;
    cs = 8'h00;
    foreach (pl_q[i]) begin
      b = pl_q[i];
      if (hx_q[i]) begin
        enc.push_back(hexs[b[7:4]]);
        enc.push_back(hexs[b[3:0]]);
      end else if (b == 8'h23 || b == 8'h24 || b == 8'h2A || b == 8'h7D) begin
        enc.push_back(8'h7D);
        enc.push_back(b ^ 8'h20);
      end else begin
        enc.push_back(b);
      end
    end
    ovf = enc.size() > 64;
    frame_q.delete();
    if (!ovf) begin
      frame_q.push_back(8'h24);
      foreach (enc[i]) begin
        frame_q.push_back(enc[i]);
        cs = 8'(cs + enc[i]);
      end
      frame_q.push_back(8'h23);
      frame_q.push_back(hexs[cs[7:4]]);
      frame_q.push_back(hexs[cs[3:0]]);
    end
  endtask

  task automatic push_frame();
    foreach (frame_q[i]) sb_q.push_back(frame_q[i]);
  endtask

  task automatic drive_beat(input logic [7:0] d, input bit h, input bit l, input bit se);
    int n;
    n = 0;
    @(negedge clk_i);
    pl_dat_i = d; pl_hex_i = h; pl_last_i = l; pl_valid_i = 1'b1; send_empty_i = se;
    @(posedge clk_i);
    while (!pl_ready_o && n < 100) begin
      n++;
      @(posedge clk_i);
    end
    #1;
    pl_valid_i = 1'b0; pl_last_i = 1'b0; send_empty_i = 1'b0;
    if (n >= 100) begin
      miscompares++;
      $error("FAIL ready_timeout obs=%0d cycles exp=<100", n);
    end
  endtask

  task automatic send_pkt(input bit se, output bit ovf);
    build_expected(ovf);
    if (!ovf) push_frame();
    foreach (pl_q[i]) drive_beat(pl_q[i], hx_q[i], i == pl_q.size() - 1, se && i == 0);
  endtask

  task automatic wait_q_empty();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 3000) begin
      miscompares++;
      $error("FAIL frame_timeout obs=%0d chars pending exp=0", sb_q.size());
    end
    repeat (4) @(negedge clk_i);
  endtask

  task automatic wait_evt(input int ev0);
    int n;
    n = 0;
    while (done_cnt + err_cnt <= ev0 && n < 3000) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 3000) begin
      miscompares++;
      $error("FAIL event_timeout obs=no done/err exp=pulse");
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic send_ack(input logic [7:0] b);
    @(negedge clk_i);
    ack_valid_i = 1'b1; ack_byte_i = b;
    @(posedge clk_i);
    #1 ack_valid_i = 1'b0;
  endtask

  task automatic finish_pkt(input int ev0, input bit ovf);
    if (!ovf) begin
      wait_q_empty();
`ifdef GDB_PKT_ACK_EN
      send_ack(8'h2B);
`endif
    end
    wait_evt(ev0);
    if (ovf) exp_err++;
    else exp_done++;
  endtask

  task automatic check_end(input string tag);
    chk({tag, "_done"}, done_cnt, exp_done);
    chk({tag, "_err"}, err_cnt, exp_err);
    chk({tag, "_sb"}, sb_q.size(), 0);
    chk({tag, "_idle"}, {busy_o, pl_ready_o}, 2'b01);
  endtask

  task automatic run_pkt(input string tag, input bit se);
    int ev0;
    bit ovf;
    ev0 = done_cnt + err_cnt;
    send_pkt(se, ovf);
    finish_pkt(ev0, ovf);
    check_end(tag);
  endtask

  initial begin
    int ev0, s0, d0, e0, n;
    bit ovf;

    // reset values
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", pl_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_tx", uart_transmit_o, 0);
    chk("rst_done_err", {done_o, err_o}, 0);
    chk("rst_byte", uart_tx_byte_o, 0);
    rst_i = 1'b0;

    // raw "g": "$g#67", '$' strobe one cycle after the last beat
    pl_q = '{8'h67}; hx_q = '{1'b0};
    ev0 = done_cnt + err_cnt;
    send_pkt(1'b0, ovf);
    @(negedge clk_i);
    chk("lat_pre", uart_transmit_o, 0);
    @(negedge clk_i);
    chk("lat_dollar", uart_transmit_o, 1);
    chk("tx_ready", pl_ready_o, 0);
    chk("tx_busy", busy_o, 1);
    finish_pkt(ev0, ovf);
    check_end("raw_g");

    // hex DE AD -> "$dead#8e"
    pl_q = '{8'hDE, 8'hAD}; hx_q = '{1'b1, 1'b1};
    run_pkt("hex_dead", 1'b0);

    // escaped '#' -> "$}\x03#80"
    pl_q = '{8'h23}; hx_q = '{1'b0};
    run_pkt("esc_hash", 1'b0);

    // empty packet "$#00"
    pl_q.delete(); hx_q.delete();
    build_expected(ovf);
    push_frame();
    ev0 = done_cnt + err_cnt;
    @(negedge clk_i);
    send_empty_i = 1'b1;
    @(posedge clk_i);
    #1 send_empty_i = 1'b0;
    finish_pkt(ev0, 1'b0);
    check_end("empty");

    // send_empty together with a payload beat: payload frame only
    pl_q = '{8'h41}; hx_q = '{1'b0};
    run_pkt("empty_vs_payload", 1'b1);
    repeat (30) @(negedge clk_i);
    chk("no_extra_frame", sb_q.size(), 0);

    // mixed payload with escapes and hex
    pl_q.delete(); hx_q.delete();
    for (int i = 0; i < 12; i++) begin
      pl_q.push_back((i % 4 == 1) ? 8'h24 : ((i % 4 == 3) ? 8'h7D : 8'($urandom_range(0, 255))));
      hx_q.push_back((i % 4 == 2) ? 1'b1 : 1'b0);
    end
    run_pkt("mixed", 1'b0);

    // exactly BUF_DEPTH encoded chars fits
    pl_q.delete(); hx_q.delete();
    for (int i = 0; i < 32; i++) begin
      pl_q.push_back(8'(i * 7 + 3));
      hx_q.push_back(1'b1);
    end
    run_pkt("full64", 1'b0);

    // 65 raw beats overflow: err, no uart strobe
    pl_q.delete(); hx_q.delete();
    for (int i = 0; i < 65; i++) begin
      pl_q.push_back(8'h61);
      hx_q.push_back(1'b0);
    end
    s0 = strobes;
    run_pkt("ovf65", 1'b0);
    chk("ovf65_no_tx", strobes, s0);

    // escape straddling the limit at count 63 overflows
    pl_q.delete(); hx_q.delete();
    for (int i = 0; i < 63; i++) begin
      pl_q.push_back(8'h62);
      hx_q.push_back(1'b0);
    end
    pl_q.push_back(8'h7D); hx_q.push_back(1'b0);
    run_pkt("ovf_esc", 1'b0);

    // overflow mid-stream: trailing beats discarded, then a normal packet
    pl_q.delete(); hx_q.delete();
    for (int i = 0; i < 70; i++) begin
      pl_q.push_back(8'h63);
      hx_q.push_back(1'b0);
    end
    s0 = strobes;
    run_pkt("ovf70", 1'b0);
    chk("ovf70_no_tx", strobes, s0);
    pl_q = '{8'h7A, 8'h2A}; hx_q = '{1'b0, 1'b0};
    run_pkt("after_ovf", 1'b0);

`ifdef GDB_PKT_ACK_EN
    // stray byte ignored, '-' replays, '+' completes
    pl_q = '{8'h4F, 8'h4B}; hx_q = '{1'b0, 1'b1};
    ev0 = done_cnt + err_cnt;
    send_pkt(1'b0, ovf);
    wait_q_empty();
    send_ack(8'h78);
    repeat (5) @(negedge clk_i);
    chk("ack_stray_busy", busy_o, 1);
    push_frame();
    send_ack(8'h2D);
    wait_q_empty();
    send_ack(8'h2B);
    wait_evt(ev0);
    exp_done++;
    check_end("ack_retry");

    // four '-' exhaust MAX_RETRY=3: four frames then err
    pl_q = '{8'h51}; hx_q = '{1'b0};
    ev0 = done_cnt + err_cnt;
    s0 = strobes;
    send_pkt(1'b0, ovf);
    for (int r = 0; r < 3; r++) begin
      wait_q_empty();
      push_frame();
      send_ack(8'h2D);
    end
    wait_q_empty();
    send_ack(8'h2D);
    wait_evt(ev0);
    exp_err++;
    check_end("ack_exhaust");
    chk("ack_exhaust_chars", strobes - s0, 4 * frame_q.size());
`endif

    // reset while in TX_BODY aborts silently
    pl_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66}; hx_q = '{6{1'b0}};
    s0 = strobes;
    send_pkt(1'b0, ovf);
    n = 0;
    while (strobes < s0 + 2 && n < 500) begin
      n++;
      @(negedge clk_i);
    end
    chk("pre_reset_chars", strobes - s0, 2);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_tx", uart_transmit_o, 0);
    chk("rst_mid_ready", pl_ready_o, 1);
    chk("rst_mid_busy", busy_o, 0);
    rst_i = 1'b0;
    sb_q.delete();
    d0 = done_cnt; e0 = err_cnt; s0 = strobes;
    repeat (60) @(negedge clk_i);
    chk("rst_mid_no_done", done_cnt, d0);
    chk("rst_mid_no_err", err_cnt, e0);
    chk("rst_mid_no_tx", strobes, s0);

    // recovery after reset
    pl_q = '{8'h21}; hx_q = '{1'b1};
    run_pkt("post_reset", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
